// File: rtl/synt_lock_ctrl_pkg.sv
// Shared types and constants for the synthesizer lock controller and its synth model.
package synt_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PWRUP,
    S_CAL,
    S_WAIT,
    S_OFF,
    S_LOCKED,
    S_ERR
  } synt_state_e;

  // Ready count of the synthesizer model: PU cycles outside calibration before RDY rises.
  localparam int SYNT_READY_COUNT = 20;
  localparam int ATTEMPT_W        = 3;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/synt_lock_ctrl_if.sv
// Request/handshake bundle between sequencer, lock controller and synthesizer.
interface synt_lock_ctrl_if;
  import synt_pkg::*;

  logic                 EN;
  logic                 RDY_SYNT;
  logic                 PU_SYNT;
  logic                 CAL_SYNT;
  logic                 LOCKED;
  logic                 BUSY;
  logic                 LOCK_ERR;
  logic [ATTEMPT_W-1:0] ATTEMPT;

  modport master (
    input  EN, RDY_SYNT,
    output PU_SYNT, CAL_SYNT, LOCKED, BUSY, LOCK_ERR, ATTEMPT
  );

  modport slave (
    output EN, RDY_SYNT,
    input  PU_SYNT, CAL_SYNT, LOCKED, BUSY, LOCK_ERR, ATTEMPT
  );
endinterface

// File: rtl/synt_lock_ctrl.sv
// Initiator side of the synthesizer power-up / calibration / lock handshake,
// with bounded wait, power-cycle retries and a sticky lock-failure flag.
module synt_lock_ctrl
  import synt_pkg::*;
#(
  parameter int PU_SETTLE   = 2,
  parameter int CAL_CYCLES  = 8,
  parameter int TIMEOUT_CYC = 64,
  parameter int PU_OFF      = 2,
  parameter int RETRIES     = 1
) (
  input  logic            CLK,
  input  logic            RSTN,
  synt_lock_ctrl_if.master sif
);

  localparam int CNT_W = $clog2(max4(PU_SETTLE, CAL_CYCLES, TIMEOUT_CYC, PU_OFF)) + 1;

  localparam logic [CNT_W-1:0]     SETTLE_LAST  = CNT_W'(PU_SETTLE - 1);
  localparam logic [CNT_W-1:0]     CAL_LAST     = CNT_W'(CAL_CYCLES - 1);
  localparam logic [CNT_W-1:0]     TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]     OFF_LAST     = CNT_W'(PU_OFF - 1);
  localparam logic [ATTEMPT_W-1:0] RETRY_LIM    = ATTEMPT_W'(RETRIES);

  synt_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ATTEMPT_W-1:0] attempt_q, attempt_d;
  logic                 err_q, err_d;
  logic                 pu_q, pu_d;
  logic                 cal_q, cal_d;
  logic                 locked_q, locked_d;
  logic                 busy_q, busy_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d   = state_q;
    attempt_d = attempt_q;
    err_d     = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (sif.EN) begin
          state_d   = S_PWRUP;
          attempt_d = '0;
          err_d     = 1'b0;
        end
      end
      S_PWRUP:  if (cnt_q == SETTLE_LAST) state_d = S_CAL;
      S_CAL:    if (cnt_q == CAL_LAST)    state_d = S_WAIT;
      S_WAIT: begin
        if (sif.RDY_SYNT) begin
          state_d = S_LOCKED;
        end else if (cnt_q == TIMEOUT_LAST) begin
          if (attempt_q < RETRY_LIM) begin
            state_d   = S_OFF;
            attempt_d = attempt_q + 1'b1;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_OFF:    if (cnt_q == OFF_LAST) state_d = S_PWRUP;
      S_LOCKED: if (!sif.RDY_SYNT)    state_d = S_ERR;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_IDLE;
    endcase

    // Dropping the request overrides ready/timeout; the error flag and attempt
    // index stay visible until the next request.
    if (!sif.EN && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      attempt_d = attempt_q;
      err_d     = err_q;
    end

    if (state_d == S_ERR) err_d = 1'b1;

    // Counter only runs in the timed states, so it cannot wrap while parked.
    if (state_d != state_q || !(state_q inside {S_PWRUP, S_CAL, S_WAIT, S_OFF}))
      cnt_d = '0;
    else
      cnt_d = cnt_q + 1'b1;

    pu_d     = state_d inside {S_PWRUP, S_CAL, S_WAIT, S_LOCKED};
    cal_d    = (state_d == S_CAL);
    locked_d = (state_d == S_LOCKED);
    busy_d   = state_d inside {S_PWRUP, S_CAL, S_WAIT, S_OFF};
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!RSTN) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      attempt_q <= '0;
      err_q     <= 1'b0;
      pu_q      <= 1'b0;
      cal_q     <= 1'b0;
      locked_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      attempt_q <= attempt_d;
      err_q     <= err_d;
      pu_q      <= pu_d;
      cal_q     <= cal_d;
      locked_q  <= locked_d;
      busy_q    <= busy_d;
    end
  end

  assign sif.PU_SYNT  = pu_q;
  assign sif.CAL_SYNT = cal_q;
  assign sif.LOCKED   = locked_q;
  assign sif.BUSY     = busy_q;
  assign sif.LOCK_ERR = err_q;
  assign sif.ATTEMPT  = attempt_q;

endmodule

// File: tb/tb_synt_lock_ctrl.sv
// Self-checking bench for synt_lock_ctrl with a behavioural synthesizer partner.
module tb_synt_lock_ctrl;
  import synt_pkg::*;

  logic CLK  = 1'b0;
  logic RSTN = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // 0: synth model drives RDY, 1: RDY forced low, 2: RDY forced high
  int   rmode = 0;
  int   model_cnt = 0;
  logic model_rdy = 1'b0;

  synt_lock_ctrl_if bus();

  synt_lock_ctrl dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .sif  (bus)
  );

  always #5 CLK = ~CLK;

  // Synth model: counts powered, non-calibrating cycles; resets when unpowered.
  always @(posedge CLK) begin
    if (bus.PU_SYNT !== 1'b1) begin
      model_cnt <= 0;
      model_rdy <= 1'b0;
    end else begin
      if (bus.CAL_SYNT !== 1'b1 && model_cnt < SYNT_READY_COUNT) model_cnt <= model_cnt + 1;
      model_rdy <= (model_cnt >= SYNT_READY_COUNT);
    end
  end

  assign bus.RDY_SYNT = (rmode == 0) ? model_rdy : (rmode == 2);

  // {PU, CAL, LOCKED, BUSY, LOCK_ERR, ATTEMPT[2:0]}
  function automatic logic [7:0] outs();
    return {bus.PU_SYNT, bus.CAL_SYNT, bus.LOCKED, bus.BUSY, bus.LOCK_ERR, bus.ATTEMPT};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Returns at the negedge just after the edge that entered S_WAIT (CAL falls, PU stays).
  task automatic wait_wait_entry(input string name);
    logic prev;
    bit   found;
    found = 1'b0;
    prev  = bus.CAL_SYNT;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge CLK);
      if (prev === 1'b1 && bus.CAL_SYNT === 1'b0 && bus.PU_SYNT === 1'b1) found = 1'b1;
      prev = bus.CAL_SYNT;
    end
    check(name, {7'd0, found}, 8'd1);
  endtask

  typedef struct {
    logic       rstn;
    logic       en;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[20];

  initial begin
    int  n;
    bit  got;

    // Reset, start, abort during CAL, restart, reach WAIT.
    vecs[0]  = '{1'b0, 1'b1, 8'h00};
    vecs[1]  = '{1'b0, 1'b1, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, 8'h00};
    vecs[3]  = '{1'b1, 1'b1, 8'h90};
    vecs[4]  = '{1'b1, 1'b1, 8'h90};
    vecs[5]  = '{1'b1, 1'b1, 8'hD0};
    vecs[6]  = '{1'b1, 1'b1, 8'hD0};
    vecs[7]  = '{1'b1, 1'b0, 8'h00};
    vecs[8]  = '{1'b1, 1'b0, 8'h00};
    vecs[9]  = '{1'b1, 1'b1, 8'h90};
    vecs[10] = '{1'b1, 1'b1, 8'h90};
    for (int i = 11; i <= 18; i++) vecs[i] = '{1'b1, 1'b1, 8'hD0};
    vecs[19] = '{1'b1, 1'b1, 8'h90};

    bus.EN = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 20; i++) begin
      RSTN   = vecs[i].rstn;
      bus.EN = vecs[i].en;
      @(negedge CLK);
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Nominal lock: EN rose 11 edges ago; lock must arrive within 40 cycles of EN.
    n   = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge CLK);
      n++;
      if (bus.LOCKED === 1'b1) got = 1'b1;
    end
    check("nom_locked", {7'd0, got}, 8'd1);
    check("nom_latency", {7'd0, (11 + n) < 40}, 8'd1);
    check("nom_outs", outs(), 8'hA0);
    repeat (3) @(negedge CLK);
    check("nom_hold", outs(), 8'hA0);

    // Lock loss: RDY drops while locked.
    rmode = 1;
    @(negedge CLK);
    check("loss_err", outs(), 8'h08);
    repeat (4) @(negedge CLK);
    check("loss_held", outs(), 8'h08);
    bus.EN = 1'b0;
    @(negedge CLK);
    check("loss_idle_sticky", outs(), 8'h08);
    bus.EN = 1'b1;
    @(negedge CLK);
    check("loss_restart_clr", outs(), 8'h90);
    bus.EN = 1'b0;
    @(negedge CLK);
    check("loss_abort_pwrup", outs(), 8'h00);

    // Timeout with one retry, RDY held low.
    bus.EN = 1'b1;
    wait_wait_entry("to_wait1");
    repeat (63) @(negedge CLK);
    check("to_last_wait1", outs(), 8'h90);
    @(negedge CLK);
    check("to_off1", outs(), 8'h11);
    @(negedge CLK);
    check("to_off2", outs(), 8'h11);
    @(negedge CLK);
    check("to_pwrup2", outs(), 8'h91);
    wait_wait_entry("to_wait2");
    repeat (63) @(negedge CLK);
    check("to_last_wait2", outs(), 8'h91);
    @(negedge CLK);
    check("to_err", outs(), 8'h09);
    repeat (5) @(negedge CLK);
    check("to_err_held", outs(), 8'h09);
    bus.EN = 1'b0;
    @(negedge CLK);
    check("to_idle_sticky", outs(), 8'h09);

    // Race: RDY rises on the final timeout cycle; ready wins, no retry.
    bus.EN = 1'b1;
    wait_wait_entry("race_wait");
    repeat (63) @(negedge CLK);
    check("race_pre", outs(), 8'h90);
    rmode = 2;
    @(negedge CLK);
    check("race_locked", outs(), 8'hA0);

    // EN drop beats RDY loss on the same edge.
    bus.EN = 1'b0;
    rmode  = 1;
    @(negedge CLK);
    check("en_beats_rdy", outs(), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
